// File: rtl/neuron_sweep_scheduler_if.sv
// Event, tick and output-spike streams of the neuron sweep scheduler.
// The router side is the master; the scheduler is the slave.
interface neuron_sweep_scheduler_if #(
    parameter int ADDR_WIDTH       = 4,
    parameter int SYN_WEIGHT_WIDTH = 4
);
    logic                        evt_valid_i;
    logic                        evt_ready_o;
    logic [ADDR_WIDTH-1:0]       evt_addr_i;
    logic [SYN_WEIGHT_WIDTH-1:0] evt_weight_i;
    logic                        tick_valid_i;
    logic                        tick_ready_o;
    logic                        spike_valid_o;
    logic                        spike_ready_i;
    logic [ADDR_WIDTH-1:0]       spike_addr_o;
    logic [7:0]                  spike_time_o;

    modport master (
        output evt_valid_i, evt_addr_i, evt_weight_i,
        output tick_valid_i, spike_ready_i,
        input  evt_ready_o, tick_ready_o,
        input  spike_valid_o, spike_addr_o, spike_time_o
    );

    modport slave (
        input  evt_valid_i, evt_addr_i, evt_weight_i,
        input  tick_valid_i, spike_ready_i,
        output evt_ready_o, tick_ready_o,
        output spike_valid_o, spike_addr_o, spike_time_o
    );
endinterface

// File: rtl/neuron_sweep_scheduler.sv
// Shares one ALIF datapath across N neuron states: integrates events
// in IDLE and sweeps every neuron through an update on each tick.
module neuron_sweep_scheduler #(
    parameter int N_NEURONS        = 16,
    parameter int STATE_WIDTH      = 32,
    parameter int SYN_WEIGHT_WIDTH = 4,
    parameter int ADDR_WIDTH       = $clog2(N_NEURONS)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    neuron_sweep_scheduler_if.slave     bus,
    output logic [2:0]                  dp_spike_op_o,
    output logic                        dp_spike_o,
    output logic [7:0]                  dp_time_o,
    output logic [SYN_WEIGHT_WIDTH-1:0] dp_syn_weight_o,
    output logic [STATE_WIDTH-1:0]      dp_state_o,
    input  logic [STATE_WIDTH-1:0]      dp_state_i,
    input  logic                        dp_spike_i,
    output logic                        busy_o,
    output logic                        sweep_done_o,
    output logic                        illegal_evt_o
);
    typedef enum logic {IDLE, SWEEP} state_e;

    localparam logic [2:0] OP_IDLE = 3'd0;
    localparam logic [2:0] OP_INT  = 3'd1;
    localparam logic [2:0] OP_UPD  = 3'd2;
    localparam logic [ADDR_WIDTH-1:0] LAST =
        ADDR_WIDTH'(N_NEURONS - 1);

    state_e                  st_q, st_d;
    logic [STATE_WIDTH-1:0]  mem_q [N_NEURONS];
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [7:0]              time_q, time_d;
    logic                    sv_q, sv_d;
    logic [ADDR_WIDTH-1:0]   sa_q, sa_d;
    logic [7:0]              st_time_q, st_time_d;
    logic                    done_q, done_d;
    logic                    ill_q, ill_d;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    evt_legal;
    logic                    stall;

    assign evt_legal = 32'(bus.evt_addr_i) < N_NEURONS;

    always_comb begin
        st_d            = st_q;
        idx_d           = idx_q;
        time_d          = time_q;
        sv_d            = sv_q;
        sa_d            = sa_q;
        st_time_d       = st_time_q;
        done_d          = 1'b0;
        ill_d           = 1'b0;
        wr_en           = 1'b0;
        wr_addr         = idx_q;
        stall           = 1'b0;
        bus.evt_ready_o  = 1'b0;
        bus.tick_ready_o = 1'b0;
        dp_spike_op_o   = OP_IDLE;
        dp_spike_o      = 1'b0;
        dp_time_o       = '0;
        dp_syn_weight_o = '0;
        dp_state_o      = '0;
        if (bus.spike_ready_i) sv_d = 1'b0;
        unique case (st_q)
            IDLE: begin
                bus.tick_ready_o = 1'b1;
                bus.evt_ready_o  = !bus.tick_valid_i;
                if (bus.tick_valid_i) begin
                    st_d  = SWEEP;
                    idx_d = '0;
                end else if (bus.evt_valid_i) begin
                    if (evt_legal) begin
                        dp_spike_op_o   = OP_INT;
                        dp_spike_o      = 1'b1;
                        dp_time_o       = time_q;
                        dp_syn_weight_o = bus.evt_weight_i;
                        dp_state_o      = mem_q[bus.evt_addr_i];
                        wr_en           = 1'b1;
                        wr_addr         = bus.evt_addr_i;
                    end else begin
                        ill_d = 1'b1;
                    end
                end
            end
            SWEEP: begin
                dp_spike_op_o = OP_UPD;
                dp_time_o     = time_q;
                dp_state_o    = mem_q[idx_q];
                // a firing neuron cannot overwrite an undelivered spike
                stall = dp_spike_i && sv_q && !bus.spike_ready_i;
                if (!stall) begin
                    wr_en = 1'b1;
                    if (dp_spike_i) begin
                        sv_d      = 1'b1;
                        sa_d      = idx_q;
                        st_time_d = time_q;
                    end
                    if (idx_q == LAST) begin
                        time_d = time_q + 8'd1;
                        done_d = 1'b1;
                        st_d   = IDLE;
                    end else begin
                        idx_d = idx_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q      <= IDLE;
            idx_q     <= '0;
            time_q    <= '0;
            sv_q      <= 1'b0;
            sa_q      <= '0;
            st_time_q <= '0;
            done_q    <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            idx_q     <= idx_d;
            time_q    <= time_d;
            sv_q      <= sv_d;
            sa_q      <= sa_d;
            st_time_q <= st_time_d;
            done_q    <= done_d;
            ill_q     <= ill_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_NEURONS; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_addr] <= dp_state_i;
        end
    end

    assign bus.spike_valid_o = sv_q;
    assign bus.spike_addr_o  = sa_q;
    assign bus.spike_time_o  = st_time_q;
    assign busy_o            = st_q == SWEEP;
    assign sweep_done_o      = done_q;
    assign illegal_evt_o     = ill_q;
endmodule

// File: tb/tb_neuron_sweep_scheduler.sv
// Bench for neuron_sweep_scheduler: vector table, hand-written corner
// sequences and random traffic against a neuron-array reference model.
module tb_neuron_sweep_scheduler;
    localparam int N  = 16;
    localparam int N2 = 12;
    localparam int SW = 32;
    localparam int WW = 4;
    localparam int AW = 4;

    typedef struct {
        bit v;
        int a;
        int w;
        int op;
        int spk;
        int st;
    } vec_t;

    typedef struct {
        int a;
        int t;
    } sp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    neuron_sweep_scheduler_if #(.ADDR_WIDTH(AW), .SYN_WEIGHT_WIDTH(WW)) bus ();
    neuron_sweep_scheduler_if #(.ADDR_WIDTH(AW), .SYN_WEIGHT_WIDTH(WW)) bus2 ();

    logic [2:0]    op, op2;
    logic          dspk, dspk2;
    logic [7:0]    dtime, dtime2;
    logic [WW-1:0] dw, dw2;
    logic [SW-1:0] dso, dso2, dsi, dsi2;
    logic          dfire, dfire2;
    logic          busy, done, ill, busy2, done2, ill2;

    neuron_sweep_scheduler #(.N_NEURONS(N)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus),
        .dp_spike_op_o(op), .dp_spike_o(dspk), .dp_time_o(dtime),
        .dp_syn_weight_o(dw), .dp_state_o(dso), .dp_state_i(dsi),
        .dp_spike_i(dfire), .busy_o(busy), .sweep_done_o(done),
        .illegal_evt_o(ill)
    );

    neuron_sweep_scheduler #(.N_NEURONS(N2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus2),
        .dp_spike_op_o(op2), .dp_spike_o(dspk2), .dp_time_o(dtime2),
        .dp_syn_weight_o(dw2), .dp_state_o(dso2), .dp_state_i(dsi2),
        .dp_spike_i(dfire2), .busy_o(busy2), .sweep_done_o(done2),
        .illegal_evt_o(ill2)
    );

    // integrate adds the weight; update fires at >= 8 and clears
    function automatic logic [SW:0] dp_model(
        input logic [2:0] o, input logic [SW-1:0] s, input logic [WW-1:0] w);
        logic [SW-1:0] wx;
        wx = {{(SW-WW){w[WW-1]}}, w};
        if (o == 3'd1) return {1'b0, s + wx};
        if (o == 3'd2) begin
            if ($signed(s) >= 8) return {1'b1, {SW{1'b0}}};
            return {1'b0, s};
        end
        return '0;
    endfunction

    assign {dfire, dsi}   = dp_model(op, dso, dw);
    assign {dfire2, dsi2} = dp_model(op2, dso2, dw2);

    int   total = 0;
    int   bad = 0;
    int   ref_st [N];
    int   ref_time = 0;
    sp_t  exq [$];
    sp_t  mon_e;
    bit   mon_en = 0;
    vec_t vt [12];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (mon_en && bus.spike_valid_o && bus.spike_ready_i) begin
            if (exq.size() == 0) begin
                chk("spike_unexpected", 1, 0);
            end else begin
                mon_e = exq.pop_front();
                chk("spike_addr", longint'(bus.spike_addr_o), mon_e.a);
                chk("spike_time", longint'(bus.spike_time_o), mon_e.t);
            end
        end
    end

    task automatic evt(input int a, input int w);
        @(negedge clk);
        bus.tick_valid_i = 1'b0;
        bus.evt_valid_i  = 1'b1;
        bus.evt_addr_i   = AW'(a);
        bus.evt_weight_i = WW'(w);
        #1;
        chk("evt_ready", longint'(bus.evt_ready_o), 1);
        chk("evt_op", longint'(op), 1);
        chk("evt_state", longint'($signed(dso)), ref_st[a]);
        chk("evt_time", longint'(dtime), ref_time);
        ref_st[a] += w;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.evt_valid_i  = 1'b0;
        bus.tick_valid_i = 1'b0;
    endtask

    task automatic do_sweep(input bit rnd);
        int  n;
        bit  got;
        sp_t e;
        for (int k = 0; k < N; k++) begin
            if (ref_st[k] >= 8) begin
                e.a = k;
                e.t = ref_time;
                exq.push_back(e);
                ref_st[k] = 0;
            end
        end
        @(negedge clk);
        bus.evt_valid_i   = 1'b0;
        bus.tick_valid_i  = 1'b1;
        bus.spike_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        chk("tick_ready", longint'(bus.tick_ready_o), 1);
        n   = 0;
        got = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            bus.tick_valid_i = 1'b0;
            n++;
            if (rnd) bus.spike_ready_i = 1'($urandom_range(0, 1));
            #1;
            if (done) got = 1;
        end
        chk("sweep_done_seen", longint'(got), 1);
        if (!rnd) chk("sweep_len", n, N + 1);
        ref_time = (ref_time + 1) % 256;
        repeat (2) begin
            @(negedge clk);
            bus.spike_ready_i = 1'b1;
        end
        #1;
        chk("spike_drained", longint'(bus.spike_valid_o), 0);
        chk("spike_queue_empty", exq.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int done_c;
        rst_n = 1'b0;
        bus.evt_valid_i = 0;  bus.evt_addr_i = '0;  bus.evt_weight_i = '0;
        bus.tick_valid_i = 0; bus.spike_ready_i = 1;
        bus2.evt_valid_i = 0; bus2.evt_addr_i = '0; bus2.evt_weight_i = '0;
        bus2.tick_valid_i = 0; bus2.spike_ready_i = 1;
        for (int i = 0; i < N; i++) ref_st[i] = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_spike_valid", longint'(bus.spike_valid_o), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_op", longint'(op), 0);
        chk("rst_time", longint'(dtime), 0);
        @(negedge clk);
        rst_n = 1'b1;

        vt[0]  = '{1, 3, 5, 1, 1, 0};
        vt[1]  = '{1, 3, 4, 1, 1, 5};
        vt[2]  = '{1, 3, 0, 1, 1, 9};
        vt[3]  = '{0, 0, 0, 0, 0, 0};
        vt[4]  = '{1, 7, -3, 1, 1, 0};
        vt[5]  = '{1, 7, -2, 1, 1, -3};
        vt[6]  = '{1, 7, 0, 1, 1, -5};
        vt[7]  = '{1, 9, 7, 1, 1, 0};
        vt[8]  = '{1, 9, 1, 1, 1, 7};
        vt[9]  = '{1, 10, 7, 1, 1, 0};
        vt[10] = '{1, 9, 0, 1, 1, 8};
        vt[11] = '{1, 10, 0, 1, 1, 7};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.evt_valid_i  = vt[i].v;
            bus.evt_addr_i   = AW'(vt[i].a);
            bus.evt_weight_i = WW'(vt[i].w);
            #1;
            chk("vec_op", longint'(op), vt[i].op);
            chk("vec_spk", longint'(dspk), vt[i].spk);
            chk("vec_state", longint'($signed(dso)), vt[i].st);
            chk("vec_weight", longint'(dw), vt[i].v ? (vt[i].w & 15) : 0);
            if (vt[i].v) ref_st[vt[i].a] += vt[i].w;
        end
        idle();

        // single spike sweep: neurons 3 and 9 fire, no backpressure
        bus.spike_ready_i = 1'b1;
        bus.tick_valid_i  = 1'b1;
        done_c = 0;
        for (c = 1; c <= 18; c++) begin
            @(negedge clk);
            bus.tick_valid_i = 1'b0;
            #1;
            if (c == 1) chk("fire_busy", longint'(busy), 1);
            if (c == 5) begin
                chk("fire_valid3", longint'(bus.spike_valid_o), 1);
                chk("fire_addr3", longint'(bus.spike_addr_o), 3);
                chk("fire_time3", longint'(bus.spike_time_o), 0);
            end
            if (c == 11) chk("fire_addr9", longint'(bus.spike_addr_o), 9);
            if (c == 12) chk("fire_valid_clr", longint'(bus.spike_valid_o), 0);
            if (done) done_c = c;
        end
        chk("fire_done_cycle", done_c, 17);
        chk("fire_busy_end", longint'(busy), 0);
        ref_st[3] = 0;
        ref_st[9] = 0;
        ref_time = 1;
        evt(3, 0);
        evt(10, 0);
        evt(7, 0);

        // backpressure: 2 fires, 5 stalls behind it
        evt(2, 7); evt(2, 1); evt(5, 7); evt(5, 2);
        idle();
        bus.spike_ready_i = 1'b0;
        bus.tick_valid_i  = 1'b1;
        done_c = 0;
        for (c = 1; c <= 24; c++) begin
            @(negedge clk);
            bus.tick_valid_i  = 1'b0;
            bus.spike_ready_i = (c == 9) || (c >= 22);
            #1;
            if (c >= 6 && c <= 8) begin
                chk("bp_busy", longint'(busy), 1);
                chk("bp_hold_addr", longint'(bus.spike_addr_o), 2);
                chk("bp_hold_idx", longint'($signed(dso)), 9);
            end
            if (c == 9) chk("bp_first_addr", longint'(bus.spike_addr_o), 2);
            if (c == 10) begin
                chk("bp_second_valid", longint'(bus.spike_valid_o), 1);
                chk("bp_second_addr", longint'(bus.spike_addr_o), 5);
                chk("bp_second_time", longint'(bus.spike_time_o), 1);
            end
            if (c == 22) chk("bp_held_valid", longint'(bus.spike_valid_o), 1);
            if (c == 23) chk("bp_drained", longint'(bus.spike_valid_o), 0);
            if (done) done_c = c;
        end
        chk("bp_done_cycle", done_c, 20);
        ref_st[2] = 0;
        ref_st[5] = 0;
        ref_time = 2;
        evt(5, 0);

        // tick beats a simultaneous event; event lands after the sweep
        @(negedge clk);
        bus.spike_ready_i = 1'b1;
        bus.tick_valid_i  = 1'b1;
        bus.evt_valid_i   = 1'b1;
        bus.evt_addr_i    = 4'd4;
        bus.evt_weight_i  = 4'd3;
        #1;
        chk("prio_evt_blocked", longint'(bus.evt_ready_o), 0);
        chk("prio_tick_ready", longint'(bus.tick_ready_o), 1);
        c = 0;
        while (!done && c < 40) begin
            @(negedge clk);
            bus.tick_valid_i = 1'b0;
            c++;
            #1;
            if (c == 1) chk("prio_sweep_evt_ready", longint'(bus.evt_ready_o), 0);
        end
        chk("prio_done_cycle", c, 17);
        chk("prio_evt_accept", longint'(bus.evt_ready_o), 1);
        chk("prio_evt_op", longint'(op), 1);
        ref_st[4] += 3;
        ref_time = 3;
        idle();
        evt(4, 0);
        idle();

        // out-of-range event on the 12-neuron instance
        @(negedge clk);
        bus2.evt_valid_i  = 1'b1;
        bus2.evt_addr_i   = 4'd14;
        bus2.evt_weight_i = 4'd5;
        #1;
        chk("ill_evt_ready", longint'(bus2.evt_ready_o), 1);
        @(negedge clk);
        bus2.evt_valid_i = 1'b0;
        #1;
        chk("ill_pulse", longint'(ill2), 1);
        @(negedge clk);
        #1;
        chk("ill_pulse_end", longint'(ill2), 0);
        @(negedge clk);
        bus2.evt_valid_i  = 1'b1;
        bus2.evt_addr_i   = 4'd11;
        bus2.evt_weight_i = 4'd2;
        for (int i = 0; i < N2; i++) begin
            @(negedge clk);
            bus2.evt_addr_i   = AW'(i);
            bus2.evt_weight_i = '0;
            #1;
            chk("ill_no_write", longint'($signed(dso2)), (i == 11) ? 2 : 0);
        end
        @(negedge clk);
        bus2.evt_valid_i = 1'b0;

        // random traffic with random output backpressure
        mon_en = 1;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) < 2) do_sweep(1);
            else evt(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 11)) - 4);
        end
        do_sweep(1);
        for (int i = 0; i < N; i++) evt(i, 0);
        idle();
        mon_en = 0;

        // reset in the middle of a sweep
        evt(6, 5);
        evt(11, 7);
        @(negedge clk);
        bus.evt_valid_i  = 1'b0;
        bus.tick_valid_i = 1'b1;
        @(negedge clk);
        bus.tick_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_sweep_busy", longint'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", longint'(busy), 0);
        chk("rst_mid_op", longint'(op), 0);
        chk("rst_mid_state", longint'(dso), 0);
        chk("rst_mid_valid", longint'(bus.spike_valid_o), 0);
        chk("rst_mid_done", longint'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exq.delete();
        for (int i = 0; i < N; i++) ref_st[i] = 0;
        ref_time = 0;
        for (int i = 0; i < N; i++) evt(i, 0);
        idle();

        // 256 sweeps wrap the time counter; last spike reports 255
        mon_en = 1;
        repeat (255) do_sweep(0);
        evt(0, 7);
        evt(0, 2);
        do_sweep(0);
        chk("wrap_time", ref_time, 0);
        evt(0, 0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
